game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES, default 3, lives loaded at game start (legal 1..3).
REQ-002 Parameter SERVE_FRAMES, default 60, frames the ball is held before release (legal 1..255).
REQ-003 clk  input  1  system clock (50 MHz); the block uses one clock and reset is synchronous and active-high.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 vsync  input  1  VGA vertical sync, active-low, asynchronous to the block's logic timing.
REQ-006 start_n  input  1  start pushbutton, active-low, unsynchronized.
REQ-007 ball_lost  input  1  one-cycle pulse: ball crossed the bottom edge.
REQ-008 collide_block  input  10  per-block one-cycle hit pulses.
REQ-009 alive  input  10  per-block alive flags.
REQ-010 state  output  3  IDLE=0, SERVE=1, PLAY=2, OVER=3, WON=4.
REQ-011 frame_tick  output  1  one-cycle pulse per frame.
REQ-012 paddle_en  output  1  paddle motion enable.
REQ-013 ball_en  output  1  ball motion enable.
REQ-014 ball_hold  output  1  ball pinned at its serve position.
REQ-015 blocks_reset  output  1  one-cycle pulse that revives all blocks.
REQ-016 lives  output  2  remaining lives.
REQ-017 score  output  8  blocks destroyed, saturating.

Function
REQ-018 vsync SHALL pass through 2 sync flops plus 1 edge flop; frame_tick SHALL be high for exactly 1 cycle, 3 rising edges after vsync is first sampled low.
REQ-019 start_n SHALL be synchronized the same way; the internal start pulse SHALL fire once per 1->0 transition, regardless of hold time.
REQ-020 IDLE: paddle_en=0, ball_en=0, ball_hold=1; start pulse -> SERVE, frame counter cleared.
REQ-021 SERVE: paddle_en=1, ball_en=0, ball_hold=1; each frame_tick increments an 8-bit counter; the tick that brings it to SERVE_FRAMES -> PLAY on the next edge.
REQ-022 PLAY: paddle_en=1, ball_en=1, ball_hold=0.
REQ-023 PLAY with alive==0 -> WON; this SHALL take priority over a same-cycle ball_lost.
REQ-024 PLAY with ball_lost and lives>1 -> lives decrements by 1, -> SERVE, counter cleared.
REQ-025 PLAY with ball_lost and lives==1 -> lives=0, -> OVER.
REQ-026 OVER and WON: all enables 0, ball_hold=1; start pulse -> IDLE, blocks_reset pulse in that same transition cycle, lives=LIVES, score=0.
REQ-027 Start pulses in SERVE/PLAY, and ball_lost outside PLAY, SHALL be ignored.
REQ-028 In PLAY, score SHALL add the popcount of collide_block each cycle (0..10), saturating at 255; collide pulses outside PLAY SHALL be ignored.
REQ-029 Outputs other than frame_tick and blocks_reset SHALL be registered decodes of state; no combinational path from any input to any output.
REQ-030 Encodings 5..7 SHALL recover to IDLE on the next edge.

Reset
REQ-031 rst high on any edge SHALL force: state=IDLE, lives=LIVES, score=0, counter=0, frame_tick=0, blocks_reset=0, paddle_en=0, ball_en=0, ball_hold=1, and sync flops=1 (inactive).
REQ-032 rst SHALL override all other inputs, including mid-PLAY and mid-SERVE; the first post-reset start press SHALL be honored.

Verification
REQ-033 Reset, then pulse start_n low 1 cycle and vsync 60 times -> IDLE->SERVE; PLAY entered exactly after the 60th frame_tick; lives=3, score=0.
REQ-034 In PLAY, collide_block=10'b0000000111 for one cycle, then 10'b1 twice -> score=5; pulses sent in SERVE -> score unchanged.
REQ-035 In PLAY, 3 ball_lost pulses, each reissued after re-entering PLAY -> lives 2, 1, then 0, ending in OVER; start -> IDLE with one blocks_reset pulse, lives=3, score=0.
REQ-036 In PLAY, alive->0 in the same cycle as ball_lost -> WON; lives unchanged.
REQ-037 Hold start_n low 1000 cycles -> exactly one start pulse; vsync low 800 cycles -> exactly one frame_tick.
REQ-038 Assert rst mid-SERVE with counter=30 -> next cycle IDLE, counter=0, all REQ-031 values.

Source files
------------

// File: rtl/game_ctrl.sv
// Game controller for a breakout-style game: synchronises vsync and the
// start button, generates the per-frame tick, and sequences the game through
// IDLE / SERVE / PLAY / OVER / WON while keeping lives and a saturating score.
module game_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       start_n,
    input  logic       ball_lost,
    input  logic [9:0] collide_block,
    input  logic [9:0] alive,
    output logic [2:0] state,
    output logic       frame_tick,
    output logic       paddle_en,
    output logic       ball_en,
    output logic       ball_hold,
    output logic       blocks_reset,
    output logic [1:0] lives,
    output logic [7:0] score
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_OVER  = 3'd3,
        S_WON   = 3'd4
    } state_t;

    localparam logic [1:0] LP_LIVES = 2'(LIVES);
    localparam logic [7:0] LP_SERVE = 8'(SERVE_FRAMES);

    // Synchroniser chains: two metastability flops plus one edge-history flop.
    logic r_vs_s1, r_vs_s2, r_vs_d;
    logic r_st_s1, r_st_s2, r_st_d;
    logic r_frame_tick;
    logic w_vs_fall;
    logic w_start_pulse;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_lives, w_lives_nxt;
    logic [7:0] r_score, w_score_nxt;
    logic       r_blocks_reset, w_blocks_reset_nxt;
    logic       r_paddle_en, r_ball_en, r_ball_hold;
    logic       w_paddle_en_nxt, w_ball_en_nxt, w_ball_hold_nxt;
    logic [3:0] w_hits;
    logic [8:0] w_score_sum;

    // Both edge detectors fire on a 1->0 transition, so a held button or a
    // long vsync low produces a single event.
    assign w_vs_fall     = r_vs_d & ~r_vs_s2;
    assign w_start_pulse = r_st_d & ~r_st_s2;

    // Synchronise vsync and start_n; idle level is 1 so reset cannot fake an edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, which is what makes
        // the chain a chain.
        if (rst) begin
            r_vs_s1      <= 1'b1;
            r_vs_s2      <= 1'b1;
            r_vs_d       <= 1'b1;
            r_st_s1      <= 1'b1;
            r_st_s2      <= 1'b1;
            r_st_d       <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_vs_s1      <= vsync;
            r_vs_s2      <= r_vs_s1;
            r_vs_d       <= r_vs_s2;
            r_st_s1      <= start_n;
            r_st_s2      <= r_st_s1;
            r_st_d       <= r_st_s2;
            r_frame_tick <= w_vs_fall;
        end
    end

    // Count simultaneous block hits and add them to the score with saturation.
    always_comb begin
        w_hits = 4'd0;
        for (int i = 0; i < 10; i++) begin
            w_hits = w_hits + {3'b000, collide_block[i]};
        end
        w_score_sum = {1'b0, r_score} + {5'b00000, w_hits};
    end

    // Next-state, lives, score and counter logic.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // that no path leaves it unassigned and a latch is never inferred.
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_lives_nxt        = r_lives;
        w_score_nxt        = r_score;
        w_blocks_reset_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_pulse) begin
                    w_state_nxt = S_SERVE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_SERVE: begin
                if (r_frame_tick) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt + 8'd1 == LP_SERVE) begin
                        w_state_nxt = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                w_score_nxt = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
                // Clearing the last block wins even if the ball is lost
                // in the same cycle.
                if (alive == 10'd0) begin
                    w_state_nxt = S_WON;
                end else if (ball_lost) begin
                    if (r_lives > 2'd1) begin
                        w_lives_nxt = r_lives - 2'd1;
                        w_state_nxt = S_SERVE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = S_OVER;
                    end
                end
            end
            S_OVER, S_WON: begin
                if (w_start_pulse) begin
                    w_state_nxt        = S_IDLE;
                    w_blocks_reset_nxt = 1'b1;
                    w_lives_nxt        = LP_LIVES;
                    w_score_nxt        = 8'd0;
                    w_cnt_nxt          = 8'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Decode the enables from the next state so the registered outputs line
    // up with the registered state.
    always_comb begin
        w_paddle_en_nxt = 1'b0;
        w_ball_en_nxt   = 1'b0;
        w_ball_hold_nxt = 1'b1;
        case (w_state_nxt)
            S_SERVE: w_paddle_en_nxt = 1'b1;
            S_PLAY: begin
                w_paddle_en_nxt = 1'b1;
                w_ball_en_nxt   = 1'b1;
                w_ball_hold_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // State register and registered game outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_lives        <= LP_LIVES;
            r_score        <= 8'd0;
            r_blocks_reset <= 1'b0;
            r_paddle_en    <= 1'b0;
            r_ball_en      <= 1'b0;
            r_ball_hold    <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_lives        <= w_lives_nxt;
            r_score        <= w_score_nxt;
            r_blocks_reset <= w_blocks_reset_nxt;
            r_paddle_en    <= w_paddle_en_nxt;
            r_ball_en      <= w_ball_en_nxt;
            r_ball_hold    <= w_ball_hold_nxt;
        end
    end

    assign state        = r_state;
    assign frame_tick   = r_frame_tick;
    assign paddle_en    = r_paddle_en;
    assign ball_en      = r_ball_en;
    assign ball_hold    = r_ball_hold;
    assign blocks_reset = r_blocks_reset;
    assign lives        = r_lives;
    assign score        = r_score;

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl: directed stimulus pushes expected output snapshots
// into a queue; a monitor pops one whenever the observable game outputs change.
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       start_n;
    logic       ball_lost;
    logic [9:0] collide_block;
    logic [9:0] alive;
    logic [2:0] state;
    logic       frame_tick;
    logic       paddle_en;
    logic       ball_en;
    logic       ball_hold;
    logic       blocks_reset;
    logic [1:0] lives;
    logic [7:0] score;

    always #5 clk = ~clk;

    game_ctrl #(.LIVES(3), .SERVE_FRAMES(60)) dut (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .start_n      (start_n),
        .ball_lost    (ball_lost),
        .collide_block(collide_block),
        .alive        (alive),
        .state        (state),
        .frame_tick   (frame_tick),
        .paddle_en    (paddle_en),
        .ball_en      (ball_en),
        .ball_hold    (ball_hold),
        .blocks_reset (blocks_reset),
        .lives        (lives),
        .score        (score)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lv;
        logic [7:0] sc;
        logic       pe;
        logic       be;
        logic       bh;
    } snap_t;

    snap_t exp_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    bit    mon_en = 0;
    int    cyc    = 0;
    int    last_tick_cyc = -100;
    int    n_ticks = 0;
    int    n_brst  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected snapshot: enables follow from the state encoding.
    function automatic snap_t mk(input logic [2:0] st, input logic [1:0] lv, input logic [7:0] sc);
        snap_t s;
        s.st = st;
        s.lv = lv;
        s.sc = sc;
        s.pe = (st == 3'd1) || (st == 3'd2);
        s.be = (st == 3'd2);
        s.bh = (st != 3'd2);
        return s;
    endfunction

    // Monitor: count pulses and compare against the scoreboard on each output change.
    snap_t prev = '1;
    snap_t cur;
    snap_t e;
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            cur = {state, lives, score, paddle_en, ball_en, ball_hold};
            if (frame_tick) begin
                n_ticks++;
                last_tick_cyc = cyc;
            end
            if (blocks_reset) n_brst++;
            if (cur != prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_change: got 0x%0h, expected no change from 0x%0h (t=%0t)",
                             cur, prev, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("outputs", 32'(cur), 32'(e));
                end
                if (cur.st == 3'd2 && prev.st == 3'd1)
                    check("play_after_tick", 32'(cyc - last_tick_cyc), 32'd1);
                prev = cur;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b0;
        step(1);
        vsync = 1'b1;
        step(4);
    endtask

    task automatic press();
        start_n = 1'b0;
        step(1);
        start_n = 1'b1;
        step(4);
    endtask

    task automatic lose_ball();
        ball_lost = 1'b1;
        step(1);
        ball_lost = 1'b0;
        step(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    int lat;
    int m;
    int brst0;
    int ticks0;

    initial begin
        rst           = 1'b1;
        vsync         = 1'b1;
        start_n       = 1'b1;
        ball_lost     = 1'b0;
        collide_block = '0;
        alive         = '1;
        step(3);
        check("reset_tick", 32'(frame_tick), 32'd0);
        check("reset_blocks_reset", 32'(blocks_reset), 32'd0);
        exp_q.push_back(mk(3'd0, 2'd3, 8'd0));
        mon_en = 1;
        step(1);
        rst = 1'b0;
        step(2);

        // frame_tick latency and a long vsync low giving a single tick
        ticks0 = n_ticks;
        vsync  = 1'b0;
        lat    = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (frame_tick && lat == 0) lat = k;
        end
        step(790);
        vsync = 1'b1;
        step(5);
        check("tick_latency", 32'(lat), 32'd3);
        check("one_tick_long_vsync", 32'(n_ticks - ticks0), 32'd1);

        // SERVE: collisions, ball_lost and start are all ignored
        exp_q.push_back(mk(3'd1, 2'd3, 8'd0));
        press();
        repeat (30) frame();
        collide_block = '1;
        step(1);
        collide_block = '0;
        lose_ball();
        press();
        check("serve_score_kept", 32'(score), 32'd0);
        check("serve_state_kept", 32'(state), 32'd1);

        // Reset mid-SERVE with counter at 30
        exp_q.push_back(mk(3'd0, 2'd3, 8'd0));
        rst = 1'b1;
        step(1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_enables", 32'({paddle_en, ball_en, ball_hold}), 32'b001);
        check("rst_pulses", 32'({frame_tick, blocks_reset}), 32'd0);
        rst = 1'b0;
        step(1);

        // First post-reset press honored; PLAY only after the 60th tick
        exp_q.push_back(mk(3'd1, 2'd3, 8'd0));
        press();
        repeat (59) frame();
        check("serve_after_59", 32'(state), 32'd1);
        exp_q.push_back(mk(3'd2, 2'd3, 8'd0));
        frame();
        check("play_after_60", 32'(state), 32'd2);

        // Scoring: 3 hits, then 1, then 1
        exp_q.push_back(mk(3'd2, 2'd3, 8'd3));
        exp_q.push_back(mk(3'd2, 2'd3, 8'd4));
        exp_q.push_back(mk(3'd2, 2'd3, 8'd5));
        collide_block = 10'b0000000111;
        step(1);
        collide_block = 10'b0000000001;
        step(2);
        collide_block = '0;
        step(1);
        check("score_5", 32'(score), 32'd5);

        // Saturation: all ten blocks hit for 26 cycles
        m = 5;
        for (int k = 0; k < 26; k++) begin
            if (m + 10 > 255) begin
                if (m != 255) exp_q.push_back(mk(3'd2, 2'd3, 8'd255));
                m = 255;
            end else begin
                m = m + 10;
                exp_q.push_back(mk(3'd2, 2'd3, 8'(m)));
            end
        end
        collide_block = '1;
        step(26);
        collide_block = '0;
        step(1);
        check("score_saturated", 32'(score), 32'd255);

        // Start in PLAY is ignored
        press();
        check("play_start_ignored", 32'(state), 32'd2);

        // Three lost balls: lives 2, 1, then OVER with 0
        exp_q.push_back(mk(3'd1, 2'd2, 8'd255));
        lose_ball();
        exp_q.push_back(mk(3'd2, 2'd2, 8'd255));
        repeat (60) frame();
        exp_q.push_back(mk(3'd1, 2'd1, 8'd255));
        lose_ball();
        exp_q.push_back(mk(3'd2, 2'd1, 8'd255));
        repeat (60) frame();
        exp_q.push_back(mk(3'd3, 2'd0, 8'd255));
        lose_ball();
        lose_ball();
        check("over_lives", 32'(lives), 32'd0);

        // Start held 1000 cycles: one pulse only -> IDLE, one blocks_reset
        brst0 = n_brst;
        exp_q.push_back(mk(3'd0, 2'd3, 8'd0));
        start_n = 1'b0;
        step(1000);
        start_n = 1'b1;
        step(5);
        check("one_blocks_reset_over", 32'(n_brst - brst0), 32'd1);
        check("idle_after_hold", 32'(state), 32'd0);

        // Win beats same-cycle ball_lost; lives unchanged
        exp_q.push_back(mk(3'd1, 2'd3, 8'd0));
        press();
        exp_q.push_back(mk(3'd2, 2'd3, 8'd0));
        repeat (60) frame();
        exp_q.push_back(mk(3'd4, 2'd3, 8'd0));
        alive     = '0;
        ball_lost = 1'b1;
        step(1);
        alive     = '1;
        ball_lost = 1'b0;
        step(2);
        check("won_lives", 32'(lives), 32'd3);
        brst0 = n_brst;
        exp_q.push_back(mk(3'd0, 2'd3, 8'd0));
        press();
        check("one_blocks_reset_won", 32'(n_brst - brst0), 32'd1);

        step(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
